// File: rtl/agc_ctr_pkg.sv
// Shared types and helpers for the counter-request priority chain.
package agc_ctr_pkg;

   localparam int unsigned CA_BASE_DEFAULT = 20;
   localparam int unsigned CA_W            = 6;

   typedef enum logic [1:0] {
      CTR_NORM,
      CTR_CDU,
      CTR_DINC,
      CTR_SHIFT
   } ctr_class_e;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      DONE
   } ctr_state_e;

   typedef struct packed {
      logic pinc;
      logic minc;
      logic pcdu;
      logic mcdu;
      logic dinc;
      logic shinc;
      logic shanc;
   } ctr_inc_t;

   // Channel class from its mask bits; the masks are disjoint by construction.
   function automatic ctr_class_e ctr_class(input logic cdu, input logic dinc, input logic shift);
      ctr_class_e cls;
      if (cdu)        cls = CTR_CDU;
      else if (dinc)  cls = CTR_DINC;
      else if (shift) cls = CTR_SHIFT;
      else            cls = CTR_NORM;
      return cls;
   endfunction

   function automatic ctr_inc_t ctr_inc_decode(input ctr_class_e cls, input logic minus);
      ctr_inc_t r;
      r = '0;
      case (cls)
         CTR_NORM:  if (minus) r.minc  = 1'b1; else r.pinc  = 1'b1;
         CTR_CDU:   if (minus) r.mcdu  = 1'b1; else r.pcdu  = 1'b1;
         CTR_DINC:  r.dinc = 1'b1;
         CTR_SHIFT: if (minus) r.shanc = 1'b1; else r.shinc = 1'b1;
         default:   r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ctr_prio_enc.sv
// Lowest-index-first priority encoder over paired plus/minus request vectors.
module ctr_prio_enc #(
   parameter int unsigned N  = 20,
   parameter int unsigned IW = 5
) (
   input  logic [N-1:0]  plus_i,
   input  logic [N-1:0]  minus_i,
   output logic          valid_o,
   output logic [IW-1:0] idx_o,
   output logic          minus_o
);

   // Scan downward so the lowest pending index is the last one written.
   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      minus_o = 1'b0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (plus_i[i] || minus_i[i]) begin
            valid_o = 1'b1;
            idx_o   = IW'(i);
            minus_o = ~plus_i[i];
         end
      end
   end

endmodule

// File: rtl/counter_priority.sv
// Counter-request priority chain: latches counter requests and steals MCTs for them.
// Optional sticky overrun flags are built when CTR_OVERRUN_EN is defined.
module counter_priority
   import agc_ctr_pkg::*;
#(
   parameter int unsigned     NCTR       = 20,
   parameter int unsigned     CA_BASE    = CA_BASE_DEFAULT,
   parameter logic [NCTR-1:0] CDU_MASK   = '0,
   parameter logic [NCTR-1:0] DINC_MASK  = '0,
   parameter logic [NCTR-1:0] SHIFT_MASK = '0
) (
   input  logic             CLOCK,
   input  logic             SIM_RST,
   input  logic             GOJAM,
   input  logic             T12_STB,
   input  logic             T07_STB,
   input  logic             INHINC,
   input  logic [NCTR-1:0]  CTR_PLUS,
   input  logic [NCTR-1:0]  CTR_MINUS,
   output logic             INKL,
   output logic             INKL_n,
   output logic [CA_W-1:0]  CTR_CA,
   output logic             PINC,
   output logic             MINC,
   output logic             PCDU,
   output logic             MCDU,
   output logic             DINC,
   output logic             SHINC,
   output logic             SHANC,
   output logic             CHINC_n,
   output logic [NCTR-1:0]  CTR_OVR
);

   localparam int unsigned IW = (NCTR > 1) ? $clog2(NCTR) : 1;

   ctr_state_e      state_q, state_d;
   logic [NCTR-1:0] p_q, p_d, m_q, m_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            minus_q, minus_d;
   logic            inkl_q, inkl_d;
   logic [CA_W-1:0] ca_q, ca_d;
   ctr_inc_t        inc_q, inc_d;
   logic            chinc_n_q, chinc_n_d;

   logic [NCTR-1:0] req_m, served_oh, clr_p, clr_m, cand_p, cand_m;
   logic [IW-1:0]   enc_idx;
   logic            enc_valid, enc_minus;
   logic            clr_now, grant_ok, start, stop;

   always_comb begin
      served_oh        = '0;
      served_oh[idx_q] = 1'b1;
   end

   // DINC channels only count upward, so their minus strobe never pends.
   assign req_m    = CTR_MINUS & ~DINC_MASK;
   assign clr_now  = (state_q == GRANT) && T07_STB;
   assign clr_p    = (clr_now && !minus_q) ? served_oh : '0;
   assign clr_m    = (clr_now &&  minus_q) ? served_oh : '0;
   assign cand_p   = p_q & ~(clr_p | clr_m);
   assign cand_m   = m_q & ~(clr_p | clr_m);
   assign grant_ok = T12_STB && enc_valid && !INHINC;

   ctr_prio_enc #(
      .N  (NCTR),
      .IW (IW)
   ) u_enc (
      .plus_i  (cand_p),
      .minus_i (cand_m),
      .valid_o (enc_valid),
      .idx_o   (enc_idx),
      .minus_o (enc_minus)
   );

   // Next-state, pending cells and registered output decode.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      minus_d   = minus_q;
      inkl_d    = inkl_q;
      ca_d      = ca_q;
      inc_d     = inc_q;
      chinc_n_d = 1'b1;
      start     = 1'b0;
      stop      = 1'b0;

      // A request in the same cycle as the clear keeps the cell set.
      p_d = (p_q & ~clr_p) | CTR_PLUS;
      m_d = (m_q & ~clr_m) | req_m;

      case (state_q)
         IDLE: begin
            if (grant_ok) start = 1'b1;
         end
         GRANT: begin
            if (T07_STB) begin
               state_d   = DONE;
               chinc_n_d = 1'b0;
            end
         end
         DONE: begin
            if (T12_STB) begin
               if (grant_ok) start = 1'b1;
               else          stop  = 1'b1;
            end
         end
         default: stop = 1'b1;
      endcase

      if (start) begin
         state_d = GRANT;
         idx_d   = enc_idx;
         minus_d = enc_minus;
         inkl_d  = 1'b1;
         ca_d    = CA_W'(CA_BASE + 32'(enc_idx));
         inc_d   = ctr_inc_decode(ctr_class(CDU_MASK[enc_idx], DINC_MASK[enc_idx],
                                            SHIFT_MASK[enc_idx]), enc_minus);
      end

      if (stop) begin
         state_d = IDLE;
         inkl_d  = 1'b0;
         ca_d    = '0;
         inc_d   = '0;
      end

      if (GOJAM) begin
         state_d   = IDLE;
         p_d       = '0;
         m_d       = '0;
         idx_d     = '0;
         minus_d   = 1'b0;
         inkl_d    = 1'b0;
         ca_d      = '0;
         inc_d     = '0;
         chinc_n_d = 1'b1;
      end
   end

   always_ff @(posedge CLOCK or posedge SIM_RST) begin
      if (SIM_RST) begin
         state_q   <= IDLE;
         p_q       <= '0;
         m_q       <= '0;
         idx_q     <= '0;
         minus_q   <= 1'b0;
         inkl_q    <= 1'b0;
         ca_q      <= '0;
         inc_q     <= '0;
         chinc_n_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         p_q       <= p_d;
         m_q       <= m_d;
         idx_q     <= idx_d;
         minus_q   <= minus_d;
         inkl_q    <= inkl_d;
         ca_q      <= ca_d;
         inc_q     <= inc_d;
         chinc_n_q <= chinc_n_d;
      end
   end

`ifdef CTR_OVERRUN_EN
   logic [NCTR-1:0] ovr_q, ovr_d;

   // A strobe on an already-set cell loses a count, unless that cell is being cleared.
   always_comb begin
      ovr_d = ovr_q | (CTR_PLUS & p_q & ~clr_p) | (req_m & m_q & ~clr_m);
      if (GOJAM) ovr_d = '0;
   end

   always_ff @(posedge CLOCK or posedge SIM_RST) begin
      if (SIM_RST) ovr_q <= '0;
      else         ovr_q <= ovr_d;
   end

   assign CTR_OVR = ovr_q;
`else
   assign CTR_OVR = '0;
`endif

   assign INKL    = inkl_q;
   assign INKL_n  = ~inkl_q;
   assign CTR_CA  = ca_q;
   assign PINC    = inc_q.pinc;
   assign MINC    = inc_q.minc;
   assign PCDU    = inc_q.pcdu;
   assign MCDU    = inc_q.mcdu;
   assign DINC    = inc_q.dinc;
   assign SHINC   = inc_q.shinc;
   assign SHANC   = inc_q.shanc;
   assign CHINC_n = chinc_n_q;

endmodule

// File: tb/tb_counter_priority.sv
// Self-checking bench for counter_priority: directed scenarios plus random traffic vs a reference model.
module tb_counter_priority;

   localparam int          NCTR   = 20;
   localparam logic [19:0] CDU_M   = 20'h00084;
   localparam logic [19:0] DINC_M  = 20'h00600;
   localparam logic [19:0] SHIFT_M = 20'h03000;

   logic        clk = 1'b0;
   logic        rst, gojam, t12, t07, inhinc;
   logic [19:0] plus, minus;
   logic        INKL, INKL_n, PINC, MINC, PCDU, MCDU, DINC, SHINC, SHANC, CHINC_n;
   logic [5:0]  CTR_CA;
   logic [19:0] CTR_OVR;
   logic [6:0]  inc_v;

   int n_chk  = 0;
   int n_pass = 0;
   int phase  = 0;

   always #5 clk = ~clk;

   assign inc_v = {PINC, MINC, PCDU, MCDU, DINC, SHINC, SHANC};

   counter_priority #(
      .NCTR       (NCTR),
      .CA_BASE    (20),
      .CDU_MASK   (CDU_M),
      .DINC_MASK  (DINC_M),
      .SHIFT_MASK (SHIFT_M)
   ) dut (
      .CLOCK     (clk),
      .SIM_RST   (rst),
      .GOJAM     (gojam),
      .T12_STB   (t12),
      .T07_STB   (t07),
      .INHINC    (inhinc),
      .CTR_PLUS  (plus),
      .CTR_MINUS (minus),
      .INKL      (INKL),
      .INKL_n    (INKL_n),
      .CTR_CA    (CTR_CA),
      .PINC      (PINC),
      .MINC      (MINC),
      .PCDU      (PCDU),
      .MCDU      (MCDU),
      .DINC      (DINC),
      .SHINC     (SHINC),
      .SHANC     (SHANC),
      .CHINC_n   (CHINC_n),
      .CTR_OVR   (CTR_OVR)
   );

   always @(posedge clk) begin
      assert (!(t12 && t07)) else $error("T12_STB and T07_STB asserted together");
   end

   // Reference model: pending requests, the channel being served and whether its T07 has passed.
   bit mp[NCTR], mm[NCTR], movr[NCTR];
   bit mact, mdone, mminus, mchinc;
   int mcur;

   always @(posedge clk or posedge rst) begin : model
      bit np[NCTR], nm[NCTR], no[NCTR];
      bit act, dn, mi, clr, rp, rm, cp, cm;
      int cur, w;
      if (rst || gojam) begin
         for (int i = 0; i < NCTR; i++) begin
            mp[i] <= 1'b0; mm[i] <= 1'b0; movr[i] <= 1'b0;
         end
         mact <= 1'b0; mdone <= 1'b0; mminus <= 1'b0; mchinc <= 1'b0; mcur <= 0;
      end else begin
         act = mact; dn = mdone; cur = mcur; mi = mminus;
         clr = act && !dn && t07;
         for (int i = 0; i < NCTR; i++) begin
            rp = plus[i];
            rm = minus[i] && !DINC_M[i];
            cp = clr && (cur == i) && !mi;
            cm = clr && (cur == i) && mi;
            no[i] = movr[i] || (rp && mp[i] && !cp) || (rm && mm[i] && !cm);
            np[i] = rp || (mp[i] && !cp);
            nm[i] = rm || (mm[i] && !cm);
         end
         if (clr) dn = 1'b1;
         if (t12 && (!act || dn)) begin
            w = -1;
            for (int i = NCTR - 1; i >= 0; i--) if (mp[i] || mm[i]) w = i;
            if (w >= 0 && !inhinc) begin
               act = 1'b1; dn = 1'b0; cur = w; mi = !mp[w];
            end else begin
               act = 1'b0; dn = 1'b0;
            end
         end
         mp <= np; mm <= nm; movr <= no;
         mact <= act; mdone <= dn; mcur <= cur; mminus <= mi; mchinc <= clr;
      end
   end

   function automatic logic [6:0] exp_inc(input bit act, input int cur, input bit mi);
      logic [19:0] c, d, s;
      c = CDU_M; d = DINC_M; s = SHIFT_M;
      if (!act)        return 7'b0000000;
      else if (c[cur]) return mi ? 7'b0001000 : 7'b0010000;
      else if (d[cur]) return 7'b0000100;
      else if (s[cur]) return mi ? 7'b0000001 : 7'b0000010;
      else             return mi ? 7'b0100000 : 7'b1000000;
   endfunction

   function automatic logic [19:0] exp_ovr();
      logic [19:0] v;
      v = '0;
`ifdef CTR_OVERRUN_EN
      for (int i = 0; i < NCTR; i++) v[i] = movr[i];
`endif
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      phase = (phase >= 12) ? 1 : phase + 1;
      t07   = (phase == 7);
      t12   = (phase == 12);
      plus  = '0;
      minus = '0;
      gojam = 1'b0;
   endtask

   task automatic step_to(input int p);
      for (int k = 0; k < 12; k++) begin
         step();
         if (phase == p) break;
      end
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      inhinc = 1'b0;
      repeat (2) step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      @(negedge clk);
      n_chk++; if (INKL !== 1'b0 || INKL_n !== 1'b1) $display("FAIL reset_inkl got=%b/%b exp=0/1", INKL, INKL_n); else n_pass++;
      n_chk++; if (CTR_CA !== 6'd0) $display("FAIL reset_ca got=%0d exp=0", CTR_CA); else n_pass++;
      n_chk++; if (inc_v !== 7'b0) $display("FAIL reset_inc got=%b exp=0000000", inc_v); else n_pass++;
      n_chk++; if (CHINC_n !== 1'b1 || CTR_OVR !== 20'h0) $display("FAIL reset_chinc_ovr got=%b/%h exp=1/0", CHINC_n, CTR_OVR); else n_pass++;
      rst = 1'b0;
      step_to(1);
      @(negedge clk);
      n_chk++; if (INKL !== 1'b0) $display("FAIL reset_idle got=%b exp=0", INKL); else n_pass++;
   endtask

   task automatic test_single();
      do_reset();
      step_to(1);
      plus[3] = 1'b1;
      step_to(1);
      @(negedge clk);
      n_chk++; if (INKL !== 1'b1 || CTR_CA !== 6'd23) $display("FAIL single_grant got=%b/%0d exp=1/23", INKL, CTR_CA); else n_pass++;
      n_chk++; if (inc_v !== 7'b1000000) $display("FAIL single_pinc got=%b exp=1000000", inc_v); else n_pass++;
      step_to(8);
      @(negedge clk);
      n_chk++; if (CHINC_n !== 1'b0) $display("FAIL single_chinc_low got=%b exp=0", CHINC_n); else n_pass++;
      step();
      @(negedge clk);
      n_chk++; if (CHINC_n !== 1'b1) $display("FAIL single_chinc_one got=%b exp=1", CHINC_n); else n_pass++;
      step_to(12);
      @(negedge clk);
      n_chk++; if (INKL !== 1'b1 || inc_v !== 7'b1000000) $display("FAIL single_hold got=%b/%b exp=1/1000000", INKL, inc_v); else n_pass++;
      step();
      @(negedge clk);
      n_chk++; if (INKL !== 1'b0 || CTR_CA !== 6'd0 || inc_v !== 7'b0) $display("FAIL single_end got=%b/%0d/%b exp=0/0/0", INKL, CTR_CA, inc_v); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int lows;
      do_reset();
      step_to(1);
      plus[5]  = 1'b1;
      minus[2] = 1'b1;
      step_to(1);
      @(negedge clk);
      n_chk++; if (INKL !== 1'b1 || CTR_CA !== 6'd22 || inc_v !== 7'b0001000) $display("FAIL b2b_first got=%b/%0d/%b exp=1/22/0001000", INKL, CTR_CA, inc_v); else n_pass++;
      lows = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         @(negedge clk);
         if (INKL !== 1'b1) lows++;
      end
      n_chk++; if (lows !== 0) $display("FAIL b2b_inkl_gap got=%0d exp=0", lows); else n_pass++;
      n_chk++; if (CTR_CA !== 6'd25 || inc_v !== 7'b1000000) $display("FAIL b2b_second got=%0d/%b exp=25/1000000", CTR_CA, inc_v); else n_pass++;
      step_to(1);
      @(negedge clk);
      n_chk++; if (INKL !== 1'b0) $display("FAIL b2b_end got=%b exp=0", INKL); else n_pass++;
   endtask

   task automatic test_collision();
      do_reset();
      step_to(1);
      plus[0] = 1'b1;
      step_to(1);
      @(negedge clk);
      n_chk++; if (INKL !== 1'b1 || CTR_CA !== 6'd20) $display("FAIL coll_first got=%b/%0d exp=1/20", INKL, CTR_CA); else n_pass++;
      step_to(7);
      plus[0] = 1'b1;
      step();
      @(negedge clk);
      n_chk++; if (CHINC_n !== 1'b0) $display("FAIL coll_chinc got=%b exp=0", CHINC_n); else n_pass++;
      step_to(1);
      @(negedge clk);
      n_chk++; if (INKL !== 1'b1 || CTR_CA !== 6'd20 || inc_v !== 7'b1000000) $display("FAIL coll_second got=%b/%0d/%b exp=1/20/1000000", INKL, CTR_CA, inc_v); else n_pass++;
      n_chk++; if (CTR_OVR[0] !== 1'b0) $display("FAIL coll_ovr got=%b exp=0", CTR_OVR[0]); else n_pass++;
      step_to(1);
      @(negedge clk);
      n_chk++; if (INKL !== 1'b0) $display("FAIL coll_end got=%b exp=0", INKL); else n_pass++;
   endtask

   task automatic test_overrun();
      logic [19:0] want;
`ifdef CTR_OVERRUN_EN
      want = 20'h00010;
`else
      want = 20'h00000;
`endif
      do_reset();
      step_to(1);
      plus[4] = 1'b1;
      step();
      plus[4] = 1'b1;
      step_to(1);
      @(negedge clk);
      n_chk++; if (INKL !== 1'b1 || CTR_CA !== 6'd24) $display("FAIL ovr_grant got=%b/%0d exp=1/24", INKL, CTR_CA); else n_pass++;
      step_to(1);
      @(negedge clk);
      n_chk++; if (INKL !== 1'b0) $display("FAIL ovr_single_grant got=%b exp=0", INKL); else n_pass++;
      n_chk++; if (CTR_OVR !== want) $display("FAIL ovr_flag got=%h exp=%h", CTR_OVR, want); else n_pass++;
      step();
      gojam = 1'b1;
      step();
      @(negedge clk);
      n_chk++; if (CTR_OVR !== 20'h0) $display("FAIL ovr_gojam_clear got=%h exp=0", CTR_OVR); else n_pass++;
   endtask

   task automatic test_inhinc();
      int highs;
      do_reset();
      step_to(1);
      plus[1] = 1'b1;
      inhinc  = 1'b1;
      highs   = 0;
      for (int k = 0; k < 36; k++) begin
         step();
         @(negedge clk);
         if (INKL !== 1'b0) highs++;
      end
      n_chk++; if (highs !== 0) $display("FAIL inh_blocked got=%0d exp=0", highs); else n_pass++;
      inhinc = 1'b0;
      step_to(1);
      @(negedge clk);
      n_chk++; if (INKL !== 1'b1 || CTR_CA !== 6'd21) $display("FAIL inh_release got=%b/%0d exp=1/21", INKL, CTR_CA); else n_pass++;
   endtask

   task automatic test_gojam();
      int highs;
      do_reset();
      step_to(1);
      plus[6]   = 1'b1;
      plus[8]   = 1'b1;
      minus[11] = 1'b1;
      step_to(1);
      @(negedge clk);
      n_chk++; if (INKL !== 1'b1 || CTR_CA !== 6'd26) $display("FAIL gj_pre got=%b/%0d exp=1/26", INKL, CTR_CA); else n_pass++;
      step_to(3);
      gojam = 1'b1;
      step();
      @(negedge clk);
      n_chk++; if (INKL !== 1'b0 || INKL_n !== 1'b1 || CTR_CA !== 6'd0) $display("FAIL gj_inkl got=%b/%b/%0d exp=0/1/0", INKL, INKL_n, CTR_CA); else n_pass++;
      n_chk++; if (inc_v !== 7'b0 || CHINC_n !== 1'b1 || CTR_OVR !== 20'h0) $display("FAIL gj_lines got=%b/%b/%h exp=0/1/0", inc_v, CHINC_n, CTR_OVR); else n_pass++;
      highs = 0;
      for (int k = 0; k < 14; k++) begin
         step();
         @(negedge clk);
         if (INKL !== 1'b0 || CHINC_n !== 1'b1) highs++;
      end
      n_chk++; if (highs !== 0) $display("FAIL gj_no_grant got=%0d exp=0", highs); else n_pass++;
   endtask

   task automatic test_random();
      logic [6:0]  ei;
      logic [5:0]  ec;
      logic [19:0] eo;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         step();
         if ($urandom_range(3, 0) == 0) plus[$urandom_range(19, 0)] = 1'b1;
         if ($urandom_range(5, 0) == 0) minus[$urandom_range(19, 0)] = 1'b1;
         if ($urandom_range(39, 0) == 0) inhinc = ~inhinc;
         if ($urandom_range(499, 0) == 0) gojam = 1'b1;
         @(negedge clk);
         ei = exp_inc(mact, mcur, mminus);
         ec = mact ? 6'(20 + mcur) : 6'd0;
         eo = exp_ovr();
         n_chk++; if (INKL !== mact || INKL_n !== !mact) $display("FAIL rnd_inkl cyc=%0d got=%b exp=%b", cyc, INKL, mact); else n_pass++;
         n_chk++; if (CTR_CA !== ec) $display("FAIL rnd_ca cyc=%0d got=%0d exp=%0d", cyc, CTR_CA, ec); else n_pass++;
         n_chk++; if (inc_v !== ei) $display("FAIL rnd_inc cyc=%0d got=%b exp=%b", cyc, inc_v, ei); else n_pass++;
         n_chk++; if (CHINC_n !== !mchinc) $display("FAIL rnd_chinc cyc=%0d got=%b exp=%b", cyc, CHINC_n, !mchinc); else n_pass++;
         n_chk++; if (CTR_OVR !== eo) $display("FAIL rnd_ovr cyc=%0d got=%h exp=%h", cyc, CTR_OVR, eo); else n_pass++;
      end
      inhinc = 1'b0;
   endtask

   initial begin
      rst    = 1'b1;
      gojam  = 1'b0;
      t12    = 1'b0;
      t07    = 1'b0;
      inhinc = 1'b0;
      plus   = '0;
      minus  = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_collision();
      test_overrun();
      test_inhinc();
      test_gojam();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/counter_priority.md
# counter_priority

Counter-request priority chain that sits directly upstream of the instruction sequencing and crosspoint logic. It latches single-cycle increment and decrement requests from peripheral counter channels and steals memory cycles for them. Per granted counter cycle it drives INKL (counter-cycle inhibit), the counter address, exactly one increment-type line (PINC, MINC, PCDU, MCDU, DINC, SHINC or SHANC), and the CHINC_n clear strobe.

## Interface

Parameters:
- NCTR, 20, number of counter channels; index 0 has highest priority.
- CA_BASE, 20 (octal 24), erasable address of channel 0; CA_BASE+NCTR-1 must be < 64.
- CDU_MASK, 'h0, per-channel bit: the channel is a CDU counter.
- DINC_MASK, 'h0, per-channel bit: the channel is a DINC counter.
- SHIFT_MASK, 'h0, per-channel bit: the channel is a shift counter. The three masks must be disjoint; a channel with no bit set is an ordinary counter.

Ports:
- CLOCK in 1: system clock. The block has one clock domain.
- SIM_RST in 1: asynchronous reset, active-high.
- GOJAM in 1: synchronous clear of all pending requests and the grant.
- T12_STB in 1: one-cycle strobe on the last clock of every memory cycle (MCT).
- T07_STB in 1: one-cycle strobe at T07 of every MCT.
- INHINC in 1: inhibits new grants; an already-granted cycle completes.
- CTR_PLUS in NCTR: one-cycle plus requests.
- CTR_MINUS in NCTR: one-cycle minus requests.
- INKL out 1: current MCT is a counter cycle.
- INKL_n out 1: complement of INKL.
- CTR_CA out 6: address of the counter being served.
- PINC, MINC, PCDU, MCDU, DINC, SHINC, SHANC out 1 each: increment type, valid while INKL is high.
- CHINC_n out 1: low for one cycle when the served request is cleared.
- CTR_OVR out NCTR: sticky per-channel overrun flags. Present only with the configuration macro.

## Operation

- Pending cells: each channel has a plus cell P[i] and a minus cell M[i]. A cell is set by the matching request strobe. For DINC channels, CTR_MINUS is ignored.
- Arbitration happens only on T12_STB, and only when the previous grant is not still active. Candidate set: channels with P[i] or M[i] set, excluding the channel currently being cleared. The lowest index wins. Within a channel, plus is served before minus. The selected index and sign are registered.
- States:
  - IDLE to GRANT: T12_STB is high, the candidate set is non-empty, and INHINC is low.
  - GRANT to DONE: on T07_STB. The served cell is cleared and CHINC_n is low for that cycle.
  - DONE to GRANT: on T12_STB, if more candidates are pending and INHINC is low. This gives back-to-back counter cycles with INKL held high continuously.
  - DONE to IDLE: on T12_STB otherwise.
- Output decode by channel class. Ordinary: PINC or MINC. CDU: PCDU or MCDU. DINC: DINC. Shift: plus gives SHINC, minus gives SHANC. Outputs are registered and are 0 outside GRANT/DONE.
- CTR_CA = CA_BASE + index, 6-bit. It holds 0 when INKL is low.
- Set/clear collision: a new request on the served cell arriving in the same cycle as the T07 clear leaves the cell set. The set wins.
- A request arriving while its cell is already set is merged, so one request is lost. With CTR_OVERRUN_EN, CTR_OVR[i] is set in that case.
- GOJAM: all cells, the grant and CTR_OVR are cleared on the next edge, and the state returns to IDLE. It overrides every simultaneous event.
- INHINC rising during GRANT does not abort the grant. It only blocks the next arbitration.

## Timing

- Reset values: INKL=0, INKL_n=1, CTR_CA=0, all increment lines 0, CHINC_n=1, CTR_OVR=0, all cells 0, state IDLE.
- Request-to-INKL latency: the request is registered one clock after its strobe. INKL rises on the clock after the next T12_STB that sees the cell set. A request arriving in the same cycle as T12_STB misses that arbitration.
- INKL and the decode lines stay stable from the clock after T12_STB through the T12_STB that ends the counter MCT, inclusive.
- CHINC_n: low exactly one clock, in the cycle after T07_STB within a granted MCT.
- T07_STB outside a grant has no effect. T12_STB and T07_STB in the same cycle is illegal; the bench asserts it never happens.

## Configuration

- CTR_OVERRUN_EN defined: the CTR_OVR register and port exist with the sticky behaviour above. The flags clear only on SIM_RST or GOJAM.
- CTR_OVERRUN_EN undefined: the CTR_OVR port is still declared and driven constant 0, and no overrun logic is built.

## Structure

- Package agc_ctr_pkg holds:
  - the channel-class enum: CTR_NORM, CTR_CDU, CTR_DINC, CTR_SHIFT;
  - the state enum: IDLE, GRANT, DONE;
  - the default CA_BASE constant;
  - the function that maps mask bits to a class.
- One sub-module, ctr_prio_enc: a parameterised lowest-index-first priority encoder that outputs a valid flag and an index, with separate plus/minus request vectors. It is purely combinational; counter_priority registers its result.

## Test plan

- Reset, then CTR_PLUS[3]=1 for one clock on an ordinary channel -> after the next T12_STB: INKL=1, CTR_CA=23, PINC=1; at T07_STB+1: CHINC_n=0; at the following T12_STB+1: INKL=0.
- CTR_PLUS[5] and CTR_MINUS[2] in the same cycle, with channel 2 a CDU channel -> two back-to-back counter MCTs with INKL held high: first MCDU with CA=22, then PINC with CA=25.
- CTR_PLUS[0] twice, the second strobe coinciding with the T07 clear -> two consecutive grants for channel 0, and CTR_OVR[0] stays 0.
- CTR_PLUS[4] twice before any grant, with CTR_OVERRUN_EN defined -> one grant only and CTR_OVR[4]=1; with the macro undefined, CTR_OVR stays 0.
- INHINC=1 while P[1] is set -> no INKL across 3 MCTs; after INHINC drops, a grant follows the next T12_STB.
- GOJAM pulse mid-GRANT with 3 cells pending -> the next clock shows all outputs at reset values, and no grant occurs at the subsequent T12_STB.
